// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit holding HI/LO and modelling multi-cycle MD latency
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   intReq     flush: cancels the instruction currently in E
//   E_inStr    instruction in E; E_RD1/E_RD2 its rs/rt operands
//   D_inStr    instruction in D, used only for the stall decision
//   E_mduRD    HI for MFHI, LO for MFLO, else 0
//   E_mduBusy  operation in flight
//   D_mduStall hold an MD instruction in D while an operation starts or runs
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        intReq,
  input  logic [31:0] E_inStr,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  input  logic [31:0] D_inStr,
  output logic [31:0] E_mduRD,
  output logic        E_mduBusy,
  output logic        D_mduStall
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  function automatic logic is_md(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'h00 && (fn inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU});
  endfunction
  logic          unused;
  logic          e_sp, e_mult, e_multu, e_div, e_divu, e_mfhi, e_mflo, e_mthi, e_mtlo;
  logic          is_mul, is_dv, start, commit;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic          pwe_q, pwe_d;
  logic [63:0]   prod;
  logic          na, nb;
  logic [31:0]   ua, ub, uq, ur, quo, rem;
  assign unused  = ^{E_inStr[25:6], D_inStr[25:6]};
  assign e_sp    = E_inStr[31:26] == 6'h00;
  assign e_mult  = e_sp && E_inStr[5:0] == F_MULT;
  assign e_multu = e_sp && E_inStr[5:0] == F_MULTU;
  assign e_div   = e_sp && E_inStr[5:0] == F_DIV;
  assign e_divu  = e_sp && E_inStr[5:0] == F_DIVU;
  assign e_mfhi  = e_sp && E_inStr[5:0] == F_MFHI;
  assign e_mflo  = e_sp && E_inStr[5:0] == F_MFLO;
  assign e_mthi  = e_sp && E_inStr[5:0] == F_MTHI;
  assign e_mtlo  = e_sp && E_inStr[5:0] == F_MTLO;
  assign is_mul  = e_mult || e_multu;
  assign is_dv   = e_div || e_divu;
  assign start   = (is_mul || is_dv) && !intReq && cnt_q == '0;
  assign commit  = cnt_q == CW'(1);
  // Low 64 bits of the product of the sign- or zero-extended operands is the exact 32x32 product.
  assign prod = (e_mult ? {{32{E_RD1[31]}}, E_RD1} : {32'b0, E_RD1})
              * (e_mult ? {{32{E_RD2[31]}}, E_RD2} : {32'b0, E_RD2});
  // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow and yields
  // truncation toward zero with the remainder taking the dividend's sign.
  assign na  = e_div && E_RD1[31];
  assign nb  = e_div && E_RD2[31];
  assign ua  = na ? -E_RD1 : E_RD1;
  assign ub  = nb ? -E_RD2 : E_RD2;
  assign uq  = E_RD2 == '0 ? '0 : ua / ub;
  assign ur  = E_RD2 == '0 ? '0 : ua % ub;
  assign quo = (na ^ nb) ? -uq : uq;
  assign rem = na ? -ur : ur;
  always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
  always_comb cnt_d = start ? (is_dv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES))
                    : cnt_q != '0 ? cnt_q - CW'(1) : '0;
  always_comb begin
    E_mduBusy  = cnt_q != '0;
    D_mduStall = (start || E_mduBusy) && is_md(D_inStr[31:26], D_inStr[5:0]);
    E_mduRD    = e_mfhi ? hi_q : e_mflo ? lo_q : '0;
  end
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = start ? (is_mul ? prod[63:32] : rem) : phi_q;
    plo_d = start ? (is_mul ? prod[31:0] : quo) : plo_q;
    // A divide by zero still occupies the unit but leaves HI/LO untouched.
    pwe_d = start ? (is_mul || E_RD2 != '0) : pwe_q;
    if (commit && pwe_q) begin
      hi_d = phi_q;
      lo_d = plo_q;
    end
    if (e_mthi && !intReq) hi_d = E_RD1;
    if (e_mtlo && !intReq) lo_d = E_RD1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      pwe_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      pwe_q <= pwe_d;
    end
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: self-checking bench for e_mdu (vector table, random ops vs reference model, corner sequences)
module tb_e_mdu;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [31:0] NOP = 32'h0;
  logic        clk = 1'b0;
  logic        reset, intReq;
  logic [31:0] E_inStr, E_RD1, E_RD2, D_inStr;
  logic [31:0] E_mduRD;
  logic        E_mduBusy, D_mduStall;
  int          tests = 0, fails = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  e_mdu dut (
    .clk(clk), .reset(reset), .intReq(intReq), .E_inStr(E_inStr), .E_RD1(E_RD1),
    .E_RD2(E_RD2), .D_inStr(D_inStr), .E_mduRD(E_mduRD), .E_mduBusy(E_mduBusy),
    .D_mduStall(D_mduStall)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;
  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int exp_cycles(input logic [5:0] fn);
    return (fn == F_MULT || fn == F_MULTU) ? 5 : (fn == F_DIV || fn == F_DIVU) ? 10 : 0;
  endfunction
  task automatic model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint      p, q, r;
    logic [63:0] u;
    case (fn)
      F_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      F_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        m_hi = u[63:32];
        m_lo = u[31:0];
      end
      F_DIV: if (b != 0) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      F_DIVU: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      default: ;
    endcase
  endtask
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    E_inStr = rtype(F_MFHI);
    #1 hi = E_mduRD;
    E_inStr = rtype(F_MFLO);
    #1 lo = E_mduRD;
    E_inStr = NOP;
  endtask
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, output int cyc);
    E_inStr = rtype(fn);
    E_RD1 = a;
    E_RD2 = b;
    @(posedge clk);
    #1 E_inStr = NOP;
    cyc = 0;
    while (E_mduBusy && cyc < 200) begin
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask
  vec_t        vt[7];
  logic [31:0] hi, lo, sh, sl, a, b;
  logic [5:0]  fn;
  int          cyc;
  logic [5:0]  ops[6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
  initial begin
    vt[0] = '{F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vt[1] = '{F_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vt[2] = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[3] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vt[4] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vt[5] = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vt[6] = '{F_DIVU,  32'd5,        32'd0,        32'h00000001, 32'hFFFFFFFD, 10};
    reset = 1'b0; intReq = 1'b0; E_inStr = NOP; D_inStr = NOP; E_RD1 = '0; E_RD2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("reset_busy", E_mduBusy, 0);
    check("reset_stall", D_mduStall, 0);
    check("rd_non_md", E_mduRD, 0);
    read_hilo(hi, lo);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    foreach (vt[i]) begin
      run_op(vt[i].fn, vt[i].a, vt[i].b, cyc);
      model(vt[i].fn, vt[i].a, vt[i].b);
      read_hilo(hi, lo);
      check($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
      check($sformatf("vec%0d_hi", i), hi, vt[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vt[i].lo);
    end
    D_inStr = rtype(F_MFLO);
    E_inStr = rtype(F_MULT);
    E_RD1 = 32'd3;
    E_RD2 = 32'd4;
    #1 check("stall_start", D_mduStall, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 E_inStr = NOP;
      #1 check($sformatf("stall_busy%0d", i), D_mduStall, 1);
      check($sformatf("busy%0d", i), E_mduBusy, 1);
      if (i == 2) begin
        D_inStr = rtype(F_ADDU);
        #1 check("stall_addu", D_mduStall, 0);
        D_inStr = rtype(F_MFLO);
      end
    end
    @(posedge clk);
    #1 check("stall_after", D_mduStall, 0);
    check("busy_after", E_mduBusy, 0);
    D_inStr = NOP;
    model(F_MULT, 32'd3, 32'd4);
    read_hilo(hi, lo);
    check("stall_mult_lo", lo, m_lo);
    intReq = 1'b1;
    E_inStr = rtype(F_MULT);
    E_RD1 = 32'd77;
    E_RD2 = 32'd99;
    @(posedge clk);
    #1 E_inStr = NOP;
    intReq = 1'b0;
    check("int_mult_busy", E_mduBusy, 0);
    repeat (6) @(posedge clk);
    #1 read_hilo(hi, lo);
    check("int_mult_hi", hi, m_hi);
    check("int_mult_lo", lo, m_lo);
    intReq = 1'b1;
    E_inStr = rtype(F_MTHI);
    E_RD1 = 32'h1234;
    @(posedge clk);
    #1 intReq = 1'b0;
    read_hilo(hi, lo);
    check("mthi_int_hi", hi, m_hi);
    E_inStr = rtype(F_MTHI);
    @(posedge clk);
    #1 E_inStr = NOP;
    model(F_MTHI, 32'h1234, 32'h0);
    read_hilo(hi, lo);
    check("mthi_hi", hi, 32'h1234);
    E_inStr = rtype(F_DIVU);
    E_RD1 = 32'd1000;
    E_RD2 = 32'd33;
    @(posedge clk);
    #1 E_inStr = NOP;
    intReq = 1'b1;
    cyc = 0;
    while (E_mduBusy && cyc < 200) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    intReq = 1'b0;
    model(F_DIVU, 32'd1000, 32'd33);
    read_hilo(hi, lo);
    check("int_busy_cycles", cyc, 10);
    check("int_busy_hi", hi, m_hi);
    check("int_busy_lo", lo, m_lo);
    for (int i = 0; i < 40; i++) begin
      fn = ops[$urandom_range(0, 5)];
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = 32'hFFFFFFFF;
        2, 3: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op(fn, a, b, cyc);
      model(fn, a, b);
      read_hilo(hi, lo);
      check($sformatf("rnd%0d_cycles fn=%0h", i, fn), cyc, exp_cycles(fn));
      check($sformatf("rnd%0d_hi fn=%0h a=%0h b=%0h", i, fn, a, b), hi, m_hi);
      check($sformatf("rnd%0d_lo fn=%0h a=%0h b=%0h", i, fn, a, b), lo, m_lo);
    end
    read_hilo(sh, sl);
    E_inStr = rtype(F_DIV);
    E_RD1 = 32'd12345;
    E_RD2 = 32'd7;
    @(posedge clk);
    #1 E_inStr = NOP;
    @(posedge clk);
    @(posedge clk);
    #1 check("rst_mid_busy_before", E_mduBusy, 1);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    check("rst_mid_busy", E_mduBusy, 0);
    read_hilo(hi, lo);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    check("rst_mid_prior_cleared", {sh, sl} != 64'h0 ? 1 : 0, 1);
    repeat (12) @(posedge clk);
    #1 check("rst_late_busy", E_mduBusy, 0);
    read_hilo(hi, lo);
    check("rst_late_hi", hi, 0);
    check("rst_late_lo", lo, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
